// File: rtl/fpu_result_stage.sv
// fpu_result_stage
//   Registered writeback stage behind the combinational FP ALU. Captures
//   {result, flags, op} under a valid/ready handshake into a small FIFO,
//   accumulates sticky IEEE exception flags and pulses trap for one cycle
//   on every accepted result that raises an enabled exception.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid / in_ready      upstream handshake (in_ready = count < DEPTH)
//   in_result/in_flags/in_op ALU result, flags {nv,dz,of,uf,nx}, op code
//   out_valid / out_ready    downstream handshake, FIFO head
//   out_result/out_flags/out_op  FIFO head contents
//   fflags, flags_clr        sticky flags and their synchronous clear
//   trap_mask, trap          per-flag trap enable, one-cycle trap pulse
//   cnt_sel, op_count        per-op counter readout
//
// Configuration
//   FPU_OPCOUNT_EN  when defined, four saturating CNT_W-bit per-op counters
//                   are built; otherwise op_count is tied to zero.

module fpu_result_stage #(
  parameter int exp   = 8,
  parameter int frac  = 23,
  parameter int width = exp + frac + 1,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_result,
  input  logic [4:0]       in_flags,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_result,
  output logic [4:0]       out_flags,
  output logic [1:0]       out_op,
  output logic [4:0]       fflags,
  input  logic             flags_clr,
  input  logic [4:0]       trap_mask,
  output logic             trap,
  input  logic [1:0]       cnt_sel,
  output logic [CNT_W-1:0] op_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = width + 7;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [4:0]    fflags_q, fflags_d;
  logic          trap_q, trap_d;
  logic          push, pop;

  // in_ready comes only from the registered count, so a full FIFO never
  // accepts in the same cycle it is popped.
  assign in_ready  = (count_q < DEPTH_C);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign {out_op, out_flags, out_result} = mem_q[rd_ptr_q];
  assign fflags = fflags_q;
  assign trap   = trap_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    fflags_d = fflags_q;
    trap_d   = 1'b0;

    // Pointers wrap naturally because DEPTH is a power of two.
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);

    // Clear takes effect before the new flags are merged in.
    if (flags_clr)  fflags_d = push ? in_flags : 5'b0;
    else if (push)  fflags_d = fflags_q | in_flags;

    trap_d = push & (|(in_flags & trap_mask));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      fflags_q <= '0;
      trap_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      fflags_q <= fflags_d;
      trap_q   <= trap_d;
    end
  end

  // Storage is reset too so the head reads as zero straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= {in_op, in_flags, in_result};
    end
  end

`ifdef FPU_OPCOUNT_EN
  logic [CNT_W-1:0] cnt_q [4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else if (push && (cnt_q[in_op] != '1)) begin
      cnt_q[in_op] <= cnt_q[in_op] + CNT_W'(1);
    end
  end

  assign op_count = cnt_q[cnt_sel];
`else
  logic unused_cnt_sel;
  assign unused_cnt_sel = ^cnt_sel;
  assign op_count       = '0;
`endif

endmodule
